spi_frame_loader: RTL and testbench

- SPI slave, mode 0, that receives display frame data and drives the write port of the pixel memory.
- Sits between the external SPI pins and the double-buffered frame memory in the display controller top.
- Generalises the fixed load/swap command path:
  - parametrised pixel byte count, address depth and bit order;
  - new load-at-address command, status readback on MISO, and overflow detection.

---
 rtl/spi_frame_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_frame_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that streams pixel frames into the frame memory write port.
// Handles load, load-at-address, swap and status-readback commands.
`timescale 1ns/1ps

module spi_frame_loader #(
    parameter int DATA_BYTES  = 3,
    parameter int ADDR_WIDTH  = 5,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spi_sclk,
    input  logic                    spi_ss,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic                    wr_en,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    swap,
    output logic                    busy
);

    localparam int DW  = 8 * DATA_BYTES;
    localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    localparam logic [7:0] CMD_LOAD = 8'hF0;
    localparam logic [7:0] CMD_ADDR = 8'hF2;
    localparam logic [7:0] CMD_SWAP = 8'h10;
    localparam logic [7:0] CMD_STAT = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADDR,
        STATUS,
        DISCARD
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] vld_sync_q, vld_sync_d;

    logic            sclk_prev_q, sclk_prev_d;
    logic            armed_q, armed_d;
    state_t          state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_vld_q, byte_vld_d;
    logic [BCW-1:0]  byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic            wr_en_q, wr_en_d;
    logic            swap_q, swap_d;
    logic            ovf_q, ovf_d;
    logic [6:0]      pcnt_q, pcnt_d;
    logic [7:0]      miso_sr_q, miso_sr_d;

    logic       sclk_s, ss_s, mosi_s;
    logic       sclk_rise, sclk_fall;
    logic       ovf_set, ovf_clr;
    logic [7:0] asm_byte;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        vld_sync_d  = {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign asm_byte  = LSB_FIRST ? {mosi_s, shift_q[7:1]}
                                 : {shift_q[6:0], mosi_s};

    always_comb begin
        sclk_prev_d = sclk_s;
        // A frame is only accepted after ss has been seen high post-reset.
        armed_d     = armed_q | (vld_sync_q[SYNC_STAGES-1] & ss_s);
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        byte_vld_d  = 1'b0;
        byte_cnt_d  = byte_cnt_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        swap_d      = 1'b0;
        pcnt_d      = pcnt_q;
        miso_sr_d   = miso_sr_q;
        ovf_set     = 1'b0;
        ovf_clr     = 1'b0;

        if (wr_en_q) begin
            wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            ovf_set   = &wr_addr_q;
            if (pcnt_q != 7'h7F) begin
                pcnt_d = pcnt_q + 7'd1;
            end
        end

        if (ss_s || !armed_q) begin
            state_d    = IDLE;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
        end else begin
            if (sclk_rise) begin
                shift_d   = asm_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_d     = asm_byte;
                    byte_vld_d = 1'b1;
                end
            end

            // The fall that closes a byte (bit_cnt 0) must not advance MISO.
            if (sclk_fall && state_q == STATUS && bit_cnt_q != 3'd0) begin
                miso_sr_d = LSB_FIRST ? {1'b0, miso_sr_q[7:1]}
                                      : {miso_sr_q[6:0], 1'b0};
            end

            if (byte_vld_q) begin
                unique case (state_q)
                    IDLE: begin
                        case (byte_q)
                            CMD_LOAD: begin
                                wr_addr_d  = '0;
                                pcnt_d     = '0;
                                byte_cnt_d = '0;
                                state_d    = LOAD;
                            end
                            CMD_ADDR: state_d = ADDR;
                            CMD_SWAP: begin
                                swap_d  = 1'b1;
                                state_d = DISCARD;
                            end
                            CMD_STAT: begin
                                miso_sr_d = {ovf_q, pcnt_q};
                                ovf_clr   = 1'b1;
                                state_d   = STATUS;
                            end
                            default: state_d = DISCARD;
                        endcase
                    end
                    ADDR: begin
                        wr_addr_d  = ADDR_WIDTH'(byte_q);
                        pcnt_d     = '0;
                        byte_cnt_d = '0;
                        state_d    = LOAD;
                    end
                    LOAD: begin
                        for (int i = 0; i < DATA_BYTES; i++) begin
                            if (byte_cnt_q == BCW'(DATA_BYTES - 1 - i)) begin
                                wr_data_d[8*i +: 8] = byte_q;
                            end
                        end
                        if (byte_cnt_q == BCW'(DATA_BYTES - 1)) begin
                            wr_en_d    = 1'b1;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BCW'(1);
                        end
                    end
                    STATUS:  state_d = DISCARD;
                    DISCARD: state_d = DISCARD;
                    default: state_d = IDLE;
                endcase
            end
        end

        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            byte_vld_q  <= 1'b0;
            byte_cnt_q  <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            swap_q      <= 1'b0;
            ovf_q       <= 1'b0;
            pcnt_q      <= '0;
            miso_sr_q   <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            vld_sync_q  <= vld_sync_d;
            sclk_prev_q <= sclk_prev_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            byte_cnt_q  <= byte_cnt_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            swap_q      <= swap_d;
            ovf_q       <= ovf_d;
            pcnt_q      <= pcnt_d;
            miso_sr_q   <= miso_sr_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign swap     = swap_q;
    assign busy     = ~ss_s;
    assign spi_miso = (state_q == STATUS) ?
                      (LSB_FIRST ? miso_sr_q[0] : miso_sr_q[7]) : 1'b0;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Bench for spi_frame_loader: default LSB-first instance plus an
// MSB-first, 2-byte, 16-deep instance sharing sclk/mosi.
`timescale 1ns/1ps

module tb_spi_frame_loader;

    localparam int HP = 4;

    logic clk = 1'b0;
    logic rst, sclk, mosi, ss_a, ss_b;

    logic        miso_a, wr_en_a, swap_a, busy_a;
    logic [4:0]  wr_addr_a;
    logic [23:0] wr_data_a;
    logic        miso_b, wr_en_b, swap_b, busy_b;
    logic [3:0]  wr_addr_b;
    logic [15:0] wr_data_b;

    int errors = 0;
    int checks = 0;
    int swaps_a = 0;
    int swaps_b = 0;

    typedef struct { logic [4:0] a; logic [23:0] d; } wa_t;
    typedef struct { logic [3:0] a; logic [15:0] d; } wb_t;
    wa_t qa[$];
    wb_t qb[$];

    typedef struct {
        logic [7:0]  addr_byte;
        logic [23:0] pix;
        logic [4:0]  exp_addr;
        logic [7:0]  exp_status;
    } vec_t;
    vec_t vecs[5];

    spi_frame_loader u_dut_a (
        .clk(clk), .rst(rst),
        .spi_sclk(sclk), .spi_ss(ss_a), .spi_mosi(mosi),
        .spi_miso(miso_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .swap(swap_a), .busy(busy_a)
    );

    spi_frame_loader #(
        .DATA_BYTES(2), .ADDR_WIDTH(4), .LSB_FIRST(1'b0), .SYNC_STAGES(2)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .spi_sclk(sclk), .spi_ss(ss_b), .spi_mosi(mosi),
        .spi_miso(miso_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .swap(swap_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (swap_a) swaps_a++;
        if (swap_b) swaps_b++;
        if (wr_en_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_a_unexpected: got addr %0h data %0h expected none",
                         wr_addr_a, wr_data_a);
            end else begin
                wa_t e;
                e = qa.pop_front();
                chk("wr_addr_a", 32'(wr_addr_a), 32'(e.a));
                chk("wr_data_a", 32'(wr_data_a), 32'(e.d));
            end
        end
        if (wr_en_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_b_unexpected: got addr %0h data %0h expected none",
                         wr_addr_b, wr_data_b);
            end else begin
                wb_t e;
                e = qb.pop_front();
                chk("wr_addr_b", 32'(wr_addr_b), 32'(e.a));
                chk("wr_data_b", 32'(wr_data_b), 32'(e.d));
            end
        end
    end

    // Mode 0 master: mosi changes with the fall, miso sampled at the rise.
    task automatic send_byte(input logic [7:0] b, input bit sel_b,
                             output logic [7:0] rx, output int lat);
        int k;
        rx  = '0;
        lat = -1;
        for (int i = 0; i < 8; i++) begin
            k = sel_b ? 7 - i : i;
            @(negedge clk);
            sclk = 1'b0;
            mosi = b[k];
            repeat (HP) @(negedge clk);
            rx[k] = sel_b ? miso_b : miso_a;
            sclk  = 1'b1;
            for (int c = 0; c < HP; c++) begin
                @(posedge clk);
                #1;
                if (i == 7 && lat < 0 &&
                    (wr_en_a || swap_a || wr_en_b || swap_b)) lat = c;
            end
        end
    endtask

    task automatic tx(input logic [7:0] b, input bit sel_b);
        logic [7:0] rx;
        int lat;
        send_byte(b, sel_b, rx, lat);
    endtask

    task automatic frame_begin(input bit sel_b);
        @(negedge clk);
        sclk = 1'b0;
        if (sel_b) ss_b = 1'b0;
        else ss_a = 1'b0;
        repeat (2 * HP) @(negedge clk);
    endtask

    task automatic frame_end();
        @(negedge clk);
        sclk = 1'b0;
        repeat (HP) @(negedge clk);
        ss_a = 1'b1;
        ss_b = 1'b1;
        repeat (2 * HP) @(negedge clk);
    endtask

    task automatic pix_a(input logic [4:0] a, input logic [23:0] d,
                         output int lat);
        logic [7:0] rx;
        qa.push_back('{a, d});
        tx(d[23:16], 1'b0);
        tx(d[15:8], 1'b0);
        send_byte(d[7:0], 1'b0, rx, lat);
    endtask

    task automatic status_read(input bit sel_b, input logic [7:0] exp,
                               input string nm);
        logic [7:0] rx;
        int lat;
        frame_begin(sel_b);
        tx(8'h20, sel_b);
        send_byte(8'h00, sel_b, rx, lat);
        frame_end();
        chk(nm, 32'(rx), 32'(exp));
    endtask

    initial begin
        int lat;
        int s0;
        logic [7:0] rx;

        vecs[0] = '{8'h00, 24'hA5A5A5, 5'd0,  8'h01};
        vecs[1] = '{8'h07, 24'h123456, 5'd7,  8'h01};
        vecs[2] = '{8'h1F, 24'hDEADBE, 5'd31, 8'h81};
        vecs[3] = '{8'hFF, 24'h0F0F0F, 5'd31, 8'h81};
        vecs[4] = '{8'h10, 24'h800001, 5'd16, 8'h01};

        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        ss_a = 1'b1;
        ss_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en_a), 0);
        chk("rst_wr_addr", 32'(wr_addr_a), 0);
        chk("rst_wr_data", 32'(wr_data_a), 0);
        chk("rst_swap", 32'(swap_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_miso", 32'(miso_a), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame_begin(1'b0);
        chk("busy_low_ss", 32'(busy_a), 1);
        tx(8'hF0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            pix_a(5'(i), {8'hFF, 8'(i), 8'hFF}, lat);
            if (i == 0) chk("wr_latency", 32'(lat), 3);
        end
        frame_end();
        chk("busy_high_ss", 32'(busy_a), 0);
        status_read(1'b0, 8'hA0, "status_full_load");

        s0 = swaps_a;
        frame_begin(1'b0);
        send_byte(8'h10, 1'b0, rx, lat);
        chk("swap_latency", 32'(lat), 3);
        tx(8'h10, 1'b0);
        frame_end();
        chk("swap_count", 32'(swaps_a - s0), 1);

        frame_begin(1'b0);
        tx(8'hF2, 1'b0);
        tx(8'h05, 1'b0);
        pix_a(5'd5, 24'h112233, lat);
        pix_a(5'd6, 24'h445566, lat);
        frame_end();
        status_read(1'b0, 8'h02, "status_after_addr");

        frame_begin(1'b0);
        tx(8'hF0, 1'b0);
        for (int i = 0; i < 33; i++) begin
            pix_a(5'(i), {8'(i), 8'(~i), 8'h5A}, lat);
        end
        frame_end();
        status_read(1'b0, 8'hA1, "status_33_ovf");
        status_read(1'b0, 8'h21, "status_reread");

        frame_begin(1'b0);
        tx(8'hF0, 1'b0);
        tx(8'hAA, 1'b0);
        tx(8'hBB, 1'b0);
        frame_end();
        frame_begin(1'b0);
        tx(8'hF0, 1'b0);
        pix_a(5'd0, 24'h010203, lat);
        frame_end();

        for (int v = 0; v < 5; v++) begin
            frame_begin(1'b0);
            tx(8'hF2, 1'b0);
            tx(vecs[v].addr_byte, 1'b0);
            pix_a(vecs[v].exp_addr, vecs[v].pix, lat);
            frame_end();
            status_read(1'b0, vecs[v].exp_status, "status_vec");
        end

        frame_begin(1'b0);
        tx(8'hF0, 1'b0);
        tx(8'h11, 1'b0);
        tx(8'h22, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_wr_en", 32'(wr_en_a), 0);
        chk("midrst_wr_addr", 32'(wr_addr_a), 0);
        chk("midrst_wr_data", 32'(wr_data_a), 0);
        chk("midrst_swap", 32'(swap_a), 0);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_miso", 32'(miso_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = swaps_a;
        tx(8'h10, 1'b0);
        frame_end();
        chk("no_swap_without_fresh_ss", 32'(swaps_a - s0), 0);
        frame_begin(1'b0);
        tx(8'hF0, 1'b0);
        pix_a(5'd0, 24'h0A0B0C, lat);
        frame_end();
        status_read(1'b0, 8'h01, "status_after_rst");

        frame_begin(1'b1);
        tx(8'hF0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            qb.push_back('{4'(i), {8'hFF, 8'(i)}});
            tx(8'hFF, 1'b1);
            tx(8'(i), 1'b1);
        end
        frame_end();
        status_read(1'b1, 8'h90, "status_b_msb");

        repeat (10) @(negedge clk);
        chk("queue_a_empty", 32'(qa.size()), 0);
        chk("queue_b_empty", 32'(qb.size()), 0);
        chk("swap_b_none", 32'(swaps_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
